// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder.
// Holds the load/run state encoding and the loader target-array select codes.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  localparam logic ADDR_SEL_IMEM = 1'b0;
  localparam logic ADDR_SEL_DMEM = 1'b1;

  typedef enum logic {
    MEM_LOAD = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with one asynchronous read port and one synchronous write port.
// Addresses are byte addresses; anything at or beyond DEPTH*4 bytes reads 0 and is never written.
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata,
  output logic              r_oob,
  output logic              w_oob
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic              unused_low_bits;

  assign widx  = waddr[IDX_W+1:2];
  assign ridx  = raddr[IDX_W+1:2];
  // Any set bit above the word index means the byte address is past the array.
  assign w_oob = |waddr[WORD_W-1:IDX_W+2];
  assign r_oob = |raddr[WORD_W-1:IDX_W+2];
  assign rdata = r_oob ? '0 : mem_q[ridx];

  assign unused_low_bits = ^{waddr[1:0], raddr[1:0]};

  always_ff @(posedge clk) begin
    if (we && !w_oob) begin
      mem_q[widx] <= wdata;
    end
  end

endmodule

// File: rtl/mips_memory.sv
// Instruction/data memory responder for the MIPS core with a loader port.
// Holds the core in reset while the loader fills both arrays, then serves fetches, loads and stores.
module mips_memory
  import mips_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_current,
  output logic [WORD_W-1:0] instr,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] wd_dm,
  input  logic              we_dm,
  output logic [WORD_W-1:0] rd_dm,
  output logic              core_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [WORD_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_go,
  output logic [WORD_W-1:0] st_count,
  output logic              err_range,
  output logic              err_align,
  output mem_state_e        state_dbg
);

  // Loader handshake: a word transfers at any edge where ld_valid && ld_ready.
  // ld_ready is high for the whole LOAD state, so ld_valid alone qualifies a transfer there.

  mem_state_e        state_q, state_d;
  logic [WORD_W-1:0] st_count_q, st_count_d;
  logic              err_range_q, err_range_d;
  logic              err_align_q, err_align_d;

  logic              run;
  logic              ld_xfer;
  logic              ld_mis;
  logic              st_req;
  logic              st_mis;
  logic              imem_we;
  logic              dmem_we;
  logic [WORD_W-1:0] dmem_waddr;
  logic [WORD_W-1:0] dmem_wdata;
  logic              imem_r_oob, imem_w_oob;
  logic              dmem_r_oob, dmem_w_oob;
  logic              ld_oob;

  always_comb begin
    run        = (state_q == MEM_RUN);
    ld_xfer    = !run && ld_valid;
    ld_mis     = (ld_addr[1:0] != 2'b00);
    st_req     = run && we_dm;
    st_mis     = (alu_out[1:0] != 2'b00);
    imem_we    = ld_xfer && (ld_sel == ADDR_SEL_IMEM) && !ld_mis;
    // The data array's single write port belongs to the loader in LOAD and to the core in RUN.
    dmem_we    = run ? (we_dm && !st_mis)
                     : (ld_xfer && (ld_sel == ADDR_SEL_DMEM) && !ld_mis);
    dmem_waddr = run ? alu_out : ld_addr;
    dmem_wdata = run ? wd_dm : ld_data;
  end

  mem_array #(.DEPTH(IMEM_WORDS)) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (pc_current),
    .rdata (instr),
    .r_oob (imem_r_oob),
    .w_oob (imem_w_oob)
  );

  mem_array #(.DEPTH(DMEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (alu_out),
    .rdata (rd_dm),
    .r_oob (dmem_r_oob),
    .w_oob (dmem_w_oob)
  );

  always_comb begin
    state_d     = state_q;
    st_count_d  = st_count_q;
    ld_oob      = (ld_sel == ADDR_SEL_IMEM) ? imem_w_oob : dmem_w_oob;
    if (!run && ld_go) begin
      state_d = MEM_RUN;
    end
    // Only stores that actually land in the array are counted.
    if (st_req && !st_mis && !dmem_w_oob) begin
      st_count_d = st_count_q + 32'd1;
    end
    err_range_d = err_range_q
                | (ld_xfer && ld_oob)
                | (st_req && dmem_w_oob)
                | (run && (imem_r_oob || dmem_r_oob));
    err_align_d = err_align_q
                | (ld_xfer && ld_mis)
                | (st_req && st_mis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_LOAD;
      st_count_q  <= '0;
      err_range_q <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_count_q  <= st_count_d;
      err_range_q <= err_range_d;
      err_align_q <= err_align_d;
    end
  end

  assign core_rst  = (state_q == MEM_LOAD);
  assign ld_ready  = (state_q == MEM_LOAD);
  assign st_count  = st_count_q;
  assign err_range = err_range_q;
  assign err_align = err_align_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_memory.sv
// Directed scoreboard bench for mips_memory: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_mips_memory;
  import mips_mem_pkg::*;

  localparam int SIG_INSTR     = 0;
  localparam int SIG_RD_DM     = 1;
  localparam int SIG_ST_COUNT  = 2;
  localparam int SIG_CORE_RST  = 3;
  localparam int SIG_LD_READY  = 4;
  localparam int SIG_ERR_RANGE = 5;
  localparam int SIG_ERR_ALIGN = 6;

  logic        clk;
  logic        rst;
  logic [31:0] pc_current;
  logic [31:0] instr;
  logic [31:0] alu_out;
  logic [31:0] wd_dm;
  logic        we_dm;
  logic [31:0] rd_dm;
  logic        core_rst;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_go;
  logic [31:0] st_count;
  logic        err_range;
  logic        err_align;
  mem_state_e  state_dbg;

  logic [31:0] exp_q[$];
  int          sig_q[$];
  string       name_q[$];
  int          n_checks;
  int          n_fail;
  logic        done;

  mips_memory #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_current (pc_current),
    .instr      (instr),
    .alu_out    (alu_out),
    .wd_dm      (wd_dm),
    .we_dm      (we_dm),
    .rd_dm      (rd_dm),
    .core_rst   (core_rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_sel     (ld_sel),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_go      (ld_go),
    .st_count   (st_count),
    .err_range  (err_range),
    .err_align  (err_align),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sig, input logic [31:0] val, input string name);
    sig_q.push_back(sig);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  task automatic load_word(input logic sel, input logic [31:0] addr, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = addr;
    ld_data  = data;
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic core_store(input logic [31:0] addr, input logic [31:0] data);
    we_dm   = 1'b1;
    alu_out = addr;
    wd_dm   = data;
    cyc();
    we_dm   = 1'b0;
  endtask

  // Scoreboard monitor: compares everything queued for the current cycle
  function automatic logic [31:0] pick(input int sig);
    case (sig)
      SIG_INSTR:     pick = instr;
      SIG_RD_DM:     pick = rd_dm;
      SIG_ST_COUNT:  pick = st_count;
      SIG_CORE_RST:  pick = {31'd0, core_rst};
      SIG_LD_READY:  pick = {31'd0, ld_ready};
      SIG_ERR_RANGE: pick = {31'd0, err_range};
      default:       pick = {31'd0, err_align};
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] a;
      int          s;
      string       nm;
      e  = exp_q.pop_front();
      s  = sig_q.pop_front();
      nm = name_q.pop_front();
      a  = pick(s);
      n_checks = n_checks + 1;
      if (a !== e) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: actual=0x%08h required=0x%08h", nm, a, e);
      end
    end
  end

  // Stimulus
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    done       = 1'b0;
    rst        = 1'b1;
    pc_current = '0;
    alu_out    = '0;
    wd_dm      = '0;
    we_dm      = 1'b0;
    ld_valid   = 1'b0;
    ld_sel     = ADDR_SEL_IMEM;
    ld_addr    = '0;
    ld_data    = '0;
    ld_go      = 1'b0;

    repeat (2) cyc();
    expect_sig(SIG_CORE_RST, 32'd1, "reset_core_rst");
    expect_sig(SIG_LD_READY, 32'd1, "reset_ld_ready");
    expect_sig(SIG_ST_COUNT, 32'd0, "reset_st_count");
    expect_sig(SIG_ERR_RANGE, 32'd0, "reset_err_range");
    expect_sig(SIG_ERR_ALIGN, 32'd0, "reset_err_align");
    cyc();
    rst = 1'b0;

    load_word(ADDR_SEL_IMEM, 32'h0, 32'h2008_0005);
    load_word(ADDR_SEL_DMEM, 32'h4, 32'hCAFE_BABE);
    load_word(ADDR_SEL_DMEM, 32'h0, 32'h1111_1111);
    load_word(ADDR_SEL_DMEM, 32'h8, 32'hAAAA_AAAA);
    load_word(ADDR_SEL_DMEM, 32'hC, 32'h3333_3333);

    // Core store and an out-of-range fetch while still loading: both ignored
    pc_current = 32'h400;
    core_store(32'hC, 32'h5555_5555);
    pc_current = 32'h0;
    expect_sig(SIG_ST_COUNT, 32'd0, "load_store_ignored_count");
    expect_sig(SIG_ERR_RANGE, 32'd0, "load_fetch_oob_no_err");
    expect_sig(SIG_CORE_RST, 32'd1, "still_loading");

    ld_go   = 1'b1;
    alu_out = 32'h4;
    cyc();
    ld_go = 1'b0;
    expect_sig(SIG_CORE_RST, 32'd0, "run_core_rst_low");
    expect_sig(SIG_LD_READY, 32'd0, "run_ld_ready_low");
    expect_sig(SIG_INSTR, 32'h2008_0005, "run_fetch_pc0");
    expect_sig(SIG_RD_DM, 32'hCAFE_BABE, "run_load_word1");
    cyc();
    alu_out = 32'hC;
    expect_sig(SIG_RD_DM, 32'h3333_3333, "load_state_store_dropped");
    cyc();

    // Store in RUN: old data same cycle, new data next cycle
    we_dm   = 1'b1;
    alu_out = 32'h8;
    wd_dm   = 32'h1234_5678;
    expect_sig(SIG_RD_DM, 32'hAAAA_AAAA, "store_same_cycle_old");
    expect_sig(SIG_ST_COUNT, 32'd0, "store_count_before");
    cyc();
    we_dm = 1'b0;
    expect_sig(SIG_RD_DM, 32'h1234_5678, "store_next_cycle_new");
    expect_sig(SIG_ST_COUNT, 32'd1, "store_count_after");

    // Loader traffic in RUN is ignored
    load_word(ADDR_SEL_DMEM, 32'h8, 32'hDEAD_BEEF);
    expect_sig(SIG_RD_DM, 32'h1234_5678, "run_loader_ignored");
    expect_sig(SIG_LD_READY, 32'd0, "run_ld_ready_stays_low");

    // Misaligned in-range store
    core_store(32'hA, 32'hFFFF_FFFF);
    alu_out = 32'h8;
    expect_sig(SIG_RD_DM, 32'h1234_5678, "misaligned_dropped");
    expect_sig(SIG_ERR_ALIGN, 32'd1, "misaligned_err_align");
    expect_sig(SIG_ERR_RANGE, 32'd0, "misaligned_no_err_range");
    expect_sig(SIG_ST_COUNT, 32'd1, "misaligned_not_counted");
    cyc();

    // Misaligned and out-of-range store
    core_store(32'h102, 32'h7777_7777);
    alu_out = 32'h0;
    expect_sig(SIG_ST_COUNT, 32'd1, "store_0x102_not_counted");
    expect_sig(SIG_ERR_ALIGN, 32'd1, "store_0x102_err_align");
    expect_sig(SIG_ERR_RANGE, 32'd1, "store_0x102_err_range");
    expect_sig(SIG_RD_DM, 32'h1111_1111, "store_0x102_dropped");
    cyc();

    // Out-of-range aligned store: reads 0, write dropped (no aliasing onto word 0)
    we_dm   = 1'b1;
    alu_out = 32'h400;
    wd_dm   = 32'h9999_9999;
    expect_sig(SIG_RD_DM, 32'h0, "oob_read_zero");
    cyc();
    we_dm   = 1'b0;
    alu_out = 32'h0;
    expect_sig(SIG_RD_DM, 32'h1111_1111, "oob_store_dropped");
    expect_sig(SIG_ERR_RANGE, 32'd1, "oob_store_err_range");
    cyc();

    // Reset mid-run: back to LOAD, state cleared, memory retained
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    alu_out    = 32'h8;
    pc_current = 32'h0;
    expect_sig(SIG_CORE_RST, 32'd1, "midrst_core_rst");
    expect_sig(SIG_LD_READY, 32'd1, "midrst_ld_ready");
    expect_sig(SIG_ST_COUNT, 32'd0, "midrst_st_count");
    expect_sig(SIG_ERR_RANGE, 32'd0, "midrst_err_range");
    expect_sig(SIG_ERR_ALIGN, 32'd0, "midrst_err_align");
    expect_sig(SIG_RD_DM, 32'h1234_5678, "midrst_dmem_retained");
    expect_sig(SIG_INSTR, 32'h2008_0005, "midrst_imem_retained");
    cyc();

    // Loader write and go in the same cycle
    ld_valid = 1'b1;
    ld_sel   = ADDR_SEL_IMEM;
    ld_addr  = 32'h4;
    ld_data  = 32'h8C09_0004;
    ld_go    = 1'b1;
    cyc();
    ld_valid   = 1'b0;
    ld_go      = 1'b0;
    pc_current = 32'h4;
    expect_sig(SIG_CORE_RST, 32'd0, "simul_go_run");
    expect_sig(SIG_INSTR, 32'h8C09_0004, "simul_word_written");
    cyc();

    // Out-of-range fetch in RUN: NOP and sticky range flag
    pc_current = 32'h400;
    expect_sig(SIG_INSTR, 32'h0, "oob_fetch_nop");
    cyc();
    pc_current = 32'h0;
    expect_sig(SIG_ERR_RANGE, 32'd1, "oob_fetch_err_range");
    cyc();
    cyc();

    if (exp_q.size() != 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_memory.md
# mips_memory

Memory responder for the MIPS core's instruction-fetch and data-memory interfaces: the target side of `pc_current`/`instr` and `alu_out`/`wd_dm`/`we_dm`/`rd_dm`. It holds separate instruction and data arrays and includes a loader port that preloads both arrays while it holds the core in reset. After the load it releases the core and serves fetches, loads and stores, counting stores and flagging illegal accesses. It sits beside the core in the system top level.

## Interface
- `IMEM_WORDS`, 64: instruction array depth in 32-bit words, power of two.
- `DMEM_WORDS`, 64: data array depth in 32-bit words, power of two.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_current`  in  32  core fetch byte address.
- `instr`  out  32  fetched instruction word.
- `alu_out`  in  32  core data byte address.
- `wd_dm`  in  32  store data.
- `we_dm`  in  1  store enable.
- `rd_dm`  out  32  load data.
- `core_rst`  out  1  reset to core, high while loading.
- `ld_valid`  in  1  loader word valid.
- `ld_ready`  out  1  loader may transfer.
- `ld_sel`  in  1  target array: 0 = instruction, 1 = data.
- `ld_addr`  in  32  loader byte address.
- `ld_data`  in  32  loader word.
- `ld_go`  in  1  end of load; start the core.
- `st_count`  out  32  accepted core stores since reset.
- `err_range`  out  1  sticky flag: out-of-range access seen.
- `err_align`  out  1  sticky flag: misaligned store seen.

## Operation
- The FSM has two states, LOAD and RUN. `rst` forces LOAD.
- **LOAD state**
  - `core_rst` = 1 and `ld_ready` = 1.
  - A transfer occurs when `ld_valid` is high at an edge. The word is written to the array selected by `ld_sel`, at word index `ld_addr[..:2]`.
  - `ld_go` at an edge moves the FSM to RUN. If `ld_valid` and `ld_go` are both high, the transfer is still performed.
  - Core stores are ignored in LOAD.
- **RUN state**
  - `core_rst` = 0 and `ld_ready` = 0. `ld_valid` is ignored.
  - RUN is left only via `rst`.
  - When `we_dm` = 1, the data array is written at `alu_out` word index and `st_count` increments, wrapping at 2^32.
- **Reads** are combinational in both states.
  - `instr` = imem[`pc_current[..:2]`].
  - `rd_dm` = dmem[`alu_out[..:2]`].
  - Low address bits are ignored on reads.
- **Range rule**
  - Any address at or beyond the array's byte size reads as 0. An instruction read of 0 is a NOP.
  - A write to such an address is dropped.
  - `err_range` sets on an out-of-range core store, or on an out-of-range loader write.
  - `err_range` sets on an out-of-range core fetch or load only while in RUN.
- **Alignment rule**
  - A core store with `alu_out[1:0]` ≠ 0 is dropped, sets `err_align`, and does not count.
  - A loader write with `ld_addr[1:0]` ≠ 0 is dropped and sets `err_align`.
- **Reset contents**: array contents are not cleared by `rst`. A reset in the middle of RUN returns to LOAD with memory retained.

## Timing
- Reset values: state = LOAD, `core_rst` = 1, `ld_ready` = 1, `st_count` = 0, `err_range` = 0, `err_align` = 0.
- `core_rst` and `ld_ready` are decoded from the state register, so there are no extra flops.
- Read latency is 0 cycles (combinational from address).
- Write latency is 1 edge. A read of the same address in the same cycle as a write returns the old data; the new data is visible in the next cycle.
- `ld_go` sampled at edge N: `core_rst` is low from cycle N+1, and the core fetches `pc_current` = 0 in that cycle.
- `st_count` and the error flags update at the same edge as the triggering access.

## Structure
- Package `mips_mem_pkg` holds:
  - the state enum (`MEM_LOAD`, `MEM_RUN`);
  - `WORD_W` = 32;
  - the `ADDR_SEL_IMEM` / `ADDR_SEL_DMEM` constants.
- Sub-module `mem_array`, parameterised by depth, instantiated twice:
  - one asynchronous read port;
  - one synchronous write port;
  - a range-check output.
- The top level holds the FSM, the write-port muxing between loader and core, the counter and the flags.

## Test plan
- **Load then run.** After `rst`, load imem[0] = 0x20080005 and dmem word 1 = 0xCAFEBABE, then pulse `ld_go`.
  - Expect `core_rst` to fall on the next cycle and `instr` = 0x20080005 at `pc_current` = 0.
  - Expect `rd_dm` = 0xCAFEBABE at `alu_out` = 4.
- **Store in RUN.** `we_dm` = 1, `alu_out` = 8, `wd_dm` = 0x12345678.
  - Same cycle: `rd_dm` shows the old value.
  - Next cycle: `rd_dm` = 0x12345678 and `st_count` = 1.
- **Illegal stores.**
  - Store to `alu_out` = 0x102 → dropped, `err_align` = 1, `st_count` unchanged.
  - Store to `alu_out` = 0x400 (DMEM_WORDS = 64) → dropped, `err_range` = 1, `rd_dm` = 0.
- **Ignored ports.**
  - Core store with `we_dm` = 1 during LOAD → no write, `st_count` = 0.
  - `ld_valid` during RUN → no write.
- **Simultaneous and mid-run reset.**
  - `ld_valid` and `ld_go` in the same cycle → the word is written and the FSM enters RUN.
  - `rst` during RUN → LOAD, `core_rst` = 1, counter and flags cleared, previously stored data still readable.
